// File: rtl/chrono_mode_ctrl.sv
// chrono_mode_ctrl
//   Stopwatch / countdown-timer mode controller with a circular lap buffer.
//   Sequences the display modes from two conditioned push-button pulses, owns
//   the tick counter, the timer preset and the lap memory.
//
// Parameters:
//   CNT_W      width of the tick counter, timer preset and each lap entry
//   LAP_DEPTH  number of lap slots (power of 2, >= 2)
//
// Ports:
//   clk        system clock
//   nrst       asynchronous active-low reset
//   pb0, pb1   one-cycle button pulses (pb0 wins when both arrive together)
//   tick       one-cycle timebase strobe
//   mode       current state encoding (IDLE=0 .. TM_DONE=7)
//   count_out  live stopwatch/timer value, or the preset while in TM_SET
//   lap_out    lap entry at lap_idx, 0 while no laps are recorded
//   lap_idx    read index of the displayed lap
//   lap_count  number of valid laps, 0..LAP_DEPTH
//   time_up    timer expired
//   running    high in SW_RUN and TM_RUN
//
// Build option:
//   TIMER_RELOAD_EN  when defined, the timer reloads the preset on expiry and
//                    keeps running, pulsing time_up for one cycle; TM_DONE is
//                    never entered. Undefined gives one-shot behaviour.

module chrono_mode_ctrl #(
   parameter int unsigned  CNT_W     = 16,
   parameter int unsigned  LAP_DEPTH = 4,
   localparam int unsigned LAP_AW    = $clog2(LAP_DEPTH)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              pb0,
   input  logic              pb1,
   input  logic              tick,
   output logic [2:0]        mode,
   output logic [CNT_W-1:0]  count_out,
   output logic [CNT_W-1:0]  lap_out,
   output logic [LAP_AW-1:0] lap_idx,
   output logic [LAP_AW:0]   lap_count,
   output logic              time_up,
   output logic              running
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StSwClr   = 3'd1,
      StSwRun   = 3'd2,
      StSwView  = 3'd3,
      StLapView = 3'd4,
      StTmSet   = 3'd5,
      StTmRun   = 3'd6,
      StTmDone  = 3'd7
   } state_e;

   localparam logic [CNT_W-1:0]  CntMax  = '1;
   localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
   localparam logic [LAP_AW-1:0] PtrOne  = LAP_AW'(1);
   localparam logic [LAP_AW:0]   LcOne   = (LAP_AW+1)'(1);
   localparam logic [LAP_AW:0]   LapFull = (LAP_AW+1)'(LAP_DEPTH);

   state_e            state;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  preset;
   logic [LAP_AW-1:0] wr_ptr;
   logic [LAP_AW-1:0] lap_step;   // how many laps back from the newest is shown
   logic [CNT_W-1:0]  lap_mem [LAP_DEPTH];
   logic              lap_wr;

   // pb1 is dropped entirely when pb0 arrives in the same cycle
   assign lap_wr = (state == StSwRun) && pb1 && !pb0;

   // Lap storage is deliberately not reset; lap_out is gated by lap_count.
   always_ff @(posedge clk) begin
      if (lap_wr) begin
         lap_mem[wr_ptr] <= count;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= StIdle;
         count     <= '0;
         preset    <= '0;
         wr_ptr    <= '0;
         lap_idx   <= '0;
         lap_step  <= '0;
         lap_count <= '0;
         time_up   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (pb0) begin
                  state <= StSwClr;
               end else if (pb1) begin
                  state <= StTmSet;
               end
            end

            StSwClr: begin
               count     <= '0;
               lap_count <= '0;
               wr_ptr    <= '0;
               state     <= StSwRun;
            end

            StSwRun: begin
               if (tick && count != CntMax) begin
                  count <= count + CntOne;
               end
               if (pb0) begin
                  state <= StSwView;
               end else if (pb1) begin
                  // the lap value itself is captured by the lap_mem write
                  wr_ptr <= wr_ptr + PtrOne;
                  if (lap_count != LapFull) begin
                     lap_count <= lap_count + LcOne;
                  end
               end
            end

            StSwView: begin
               if (pb0) begin
                  if (lap_count != '0) begin
                     state    <= StLapView;
                     lap_idx  <= wr_ptr - PtrOne;
                     lap_step <= '0;
                  end else begin
                     state <= StIdle;
                  end
               end else if (pb1) begin
                  state <= StSwRun;
               end
            end

            StLapView: begin
               if (pb0) begin
                  state <= StIdle;
               end else if (pb1) begin
                  // past the oldest valid lap, wrap back to the newest
                  if ((LAP_AW+1)'(lap_step) + LcOne == lap_count) begin
                     lap_step <= '0;
                     lap_idx  <= wr_ptr - PtrOne;
                  end else begin
                     lap_step <= lap_step + PtrOne;
                     lap_idx  <= lap_idx - PtrOne;
                  end
               end
            end

            StTmSet: begin
               if (pb0) begin
                  if (preset != '0) begin
                     count <= preset;
                     state <= StTmRun;
                  end else begin
                     state <= StIdle;
                  end
               end else if (pb1) begin
                  preset <= preset + CntOne;
               end
            end

            StTmRun: begin
               time_up <= 1'b0;
               if (pb0) begin
                  // abort keeps the current count on display
                  state <= StIdle;
               end else if (tick) begin
                  if (count == CntOne) begin
                     time_up <= 1'b1;
`ifdef TIMER_RELOAD_EN
                     count   <= preset;
`else
                     count   <= '0;
                     state   <= StTmDone;
`endif
                  end else begin
                     count <= count - CntOne;
                  end
               end
            end

            StTmDone: begin
               if (pb0) begin
                  state   <= StIdle;
                  time_up <= 1'b0;
               end
            end
         endcase
      end
   end

   // Outputs decode straight from state registers only.
   assign mode      = state;
   assign count_out = (state == StTmSet) ? preset : count;
   assign lap_out   = (lap_count != '0) ? lap_mem[lap_idx] : '0;
   assign running   = (state == StSwRun) || (state == StTmRun);

endmodule

// File: tb/tb_chrono_mode_ctrl.sv
// tb_chrono_mode_ctrl
//   Scoreboard bench for chrono_mode_ctrl (CNT_W=4, LAP_DEPTH=4). Each driven
//   cycle updates a behavioural model and queues the expected outputs; a
//   monitor pops and compares them after the clock edge.
//   Define TIMER_RELOAD_EN for both RTL and bench to exercise the periodic timer.

module tb_chrono_mode_ctrl;

   localparam int unsigned CW    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;
   localparam int          MAXC  = 15;

   logic          clk = 1'b0;
   logic          nrst;
   logic          pb0, pb1, tick;
   logic [2:0]    mode;
   logic [CW-1:0] count_out;
   logic [CW-1:0] lap_out;
   logic [AW-1:0] lap_idx;
   logic [AW:0]   lap_count;
   logic          time_up;
   logic          running;

   chrono_mode_ctrl #(
      .CNT_W     (CW),
      .LAP_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .pb0       (pb0),
      .pb1       (pb1),
      .tick      (tick),
      .mode      (mode),
      .count_out (count_out),
      .lap_out   (lap_out),
      .lap_idx   (lap_idx),
      .lap_count (lap_count),
      .time_up   (time_up),
      .running   (running)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mode;
      int count;
      int lap;
      int idx;
      int lc;
      int tu;
      int run;
   } snap_t;

   snap_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_mode, m_count, m_preset, m_wr, m_lc, m_idx, m_view, m_tu;
   int m_ring[DEPTH];

   task automatic model_reset();
      m_mode = 0; m_count = 0; m_preset = 0; m_wr = 0;
      m_lc = 0; m_idx = 0; m_view = 0; m_tu = 0;
   endtask

   task automatic model_step(input bit p0, input bit p1_raw, input bit t);
      bit p1;
      p1 = p1_raw && !p0;
      case (m_mode)
         0: if (p0) m_mode = 1; else if (p1) m_mode = 5;
         1: begin m_count = 0; m_lc = 0; m_wr = 0; m_mode = 2; end
         2: begin
            if (p1) begin
               m_ring[m_wr] = m_count;
               m_wr = (m_wr + 1) % DEPTH;
               if (m_lc < DEPTH) m_lc++;
            end
            if (t && m_count < MAXC) m_count++;
            if (p0) m_mode = 3;
         end
         3: begin
            if (p0) begin
               if (m_lc > 0) begin
                  m_mode = 4; m_view = 0; m_idx = (m_wr + DEPTH - 1) % DEPTH;
               end else m_mode = 0;
            end else if (p1) m_mode = 2;
         end
         4: begin
            if (p0) m_mode = 0;
            else if (p1) begin
               m_view = (m_view + 1 == m_lc) ? 0 : m_view + 1;
               m_idx  = (m_wr + 2 * DEPTH - 1 - m_view) % DEPTH;
            end
         end
         5: begin
            if (p0) begin
               if (m_preset != 0) begin m_count = m_preset; m_mode = 6; end
               else m_mode = 0;
            end else if (p1) m_preset = (m_preset + 1) % (MAXC + 1);
         end
         6: begin
            m_tu = 0;
            if (p0) m_mode = 0;
            else if (t) begin
               if (m_count == 1) begin
                  m_tu = 1;
`ifdef TIMER_RELOAD_EN
                  m_count = m_preset;
`else
                  m_count = 0; m_mode = 7;
`endif
               end else m_count--;
            end
         end
         default: if (p0) begin m_mode = 0; m_tu = 0; end
      endcase
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.mode  = m_mode;
      s.count = (m_mode == 5) ? m_preset : m_count;
      s.lap   = (m_lc == 0) ? 0 : m_ring[m_idx];
      s.idx   = m_idx;
      s.lc    = m_lc;
      s.tu    = m_tu;
      s.run   = (m_mode == 2 || m_mode == 6) ? 1 : 0;
      return s;
   endfunction

   // Drive one cycle of stimulus and queue the outputs expected after the edge.
   task automatic step(input bit p0, input bit p1, input bit t);
      @(negedge clk);
      pb0 = p0; pb1 = p1; tick = t;
      model_step(p0, p1, t);
      exp_q.push_back(model_snap());
   endtask

   // Monitor: compare after each active edge, away from it.
   always @(posedge clk) begin
      #2;
      pb0 = 1'b0; pb1 = 1'b0; tick = 1'b0;
      if (exp_q.size() > 0) begin
         snap_t e;
         e = exp_q.pop_front();
         check("mode",      mode,      e.mode);
         check("count_out", count_out, e.count);
         check("lap_out",   lap_out,   e.lap);
         check("lap_idx",   lap_idx,   e.idx);
         check("lap_count", lap_count, e.lc);
         check("time_up",   time_up,   e.tu);
         check("running",   running,   e.run);
      end
   end

   initial begin
      nrst = 1'b0; pb0 = 1'b0; pb1 = 1'b0; tick = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_mode",  mode,      0);
      check("rst_count", count_out, 0);
      check("rst_lc",    lap_count, 0);
      check("rst_idx",   lap_idx,   0);
      check("rst_tu",    time_up,   0);
      check("rst_run",   running,   0);
      check("rst_lap",   lap_out,   0);
      nrst = 1'b1;

      // basic stopwatch with one lap at count 5
      step(1, 0, 0);
      step(0, 0, 0);
      repeat (5) step(0, 0, 1);
      step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 1, 0);                 // single lap: stepping stays on newest
      step(1, 0, 0);

      // five laps into four slots, oldest overwritten, then browse
      step(1, 0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1);
         step(0, 1, 0);
      end
      step(1, 0, 0);
      step(1, 0, 0);
      repeat (4) step(0, 1, 0);
      step(1, 0, 0);

      // pb0+pb1 together in SW_RUN, frozen view, resume, empty lap list exit
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(1, 1, 1);
      step(0, 0, 1);
      step(0, 1, 0);
      step(0, 0, 1);
      step(1, 0, 0);
      step(1, 0, 0);

      // countdown from preset 3
      step(0, 1, 0);
      repeat (3) step(0, 1, 0);
      step(1, 0, 0);
      step(0, 1, 0);                 // ignored in TM_RUN
      repeat (3) step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 1);
      step(1, 0, 0);

      // counter saturation, plus a lap holding the saturated value
      step(1, 0, 0);
      step(0, 0, 0);
      repeat (20) step(0, 0, 1);
      step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);

      // preset wrap 15 -> 0 (currently 3), then pb0 with zero preset
      step(0, 1, 0);
      repeat (13) step(0, 1, 0);
      step(1, 0, 0);

      // preset 2, run six ticks (one-shot vs periodic)
      step(0, 1, 0);
      repeat (2) step(0, 1, 0);
      step(1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1);
         step(0, 0, 0);
      end
      step(1, 0, 0);

      // asynchronous reset in the middle of TM_RUN with count 7
      step(0, 1, 0);
      repeat (5) step(0, 1, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      @(posedge clk);
      #3;
      check("pre_rst_count", count_out, 7);
      nrst = 1'b0;
      #1;
      check("arst_mode",  mode,      0);
      check("arst_count", count_out, 0);
      check("arst_lc",    lap_count, 0);
      check("arst_run",   running,   0);
      model_reset();
      @(negedge clk);
      nrst = 1'b1;

      // preset cleared by reset
      step(0, 1, 0);
      step(0, 0, 0);
      step(1, 0, 0);

      @(posedge clk);
      #3;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
